// File: rtl/pciecfg_pkg.sv
// Shared constants and types for the emulated PCIe config-space responder:
// reset image, per-dword write masks, status dword index and FSM state type.
package pciecfg_pkg;

    localparam int PCIECFG_STATUS_DW   = 1;
    localparam int PCIECFG_TABLE_DEPTH = 1024;

    // Type 0 header image: vendor/device, status/command, class code, cap pointer.
    localparam logic [31:0] PCIECFG_INIT [PCIECFG_TABLE_DEPTH] = '{
        0:       32'h7022_10EE,
        1:       32'h0010_0000,
        2:       32'h0580_0000,
        13:      32'h0000_0040,
        default: 32'h0000_0000
    };

    localparam logic [31:0] PCIECFG_WMASK [PCIECFG_TABLE_DEPTH] = '{
        1:       32'hF900_0547,
        3:       32'h0000_FF00,
        4:       32'hFFFF_FFF0,
        15:      32'h0000_00FF,
        default: 32'h0000_0000
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } pciecfg_state_e;

    function automatic logic [31:0] be_expand(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

endpackage

// File: rtl/pciecfg_target_regs.sv
// Write-masked config dword store with status_set merge on dword 1.
// PCIECFG_TARGET_RW1C_EN makes dword 1 bits [31:16] write-one-to-clear.
module pciecfg_target_regs
    import pciecfg_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [9:0]  addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] di,
    input  logic [15:0] status_set,
    output logic [31:0] rd_data,
    output logic [15:0] command
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   regs_q [DEPTH];
    logic [31:0]   regs_d [DEPTH];
    logic          in_range;
    logic [AW-1:0] idx;
    logic [31:0]   old_val;
    logic [31:0]   m;
    logic [31:0]   wr_val;

    assign in_range = ({22'd0, addr} < 32'(DEPTH));
    assign idx      = addr[AW-1:0];
    assign old_val  = in_range ? regs_q[idx] : 32'h0;
    assign m        = PCIECFG_WMASK[addr] & be_expand(byte_en);
    assign rd_data  = old_val;
    assign command  = regs_q[PCIECFG_STATUS_DW][15:0];

    always_comb begin
        wr_val = (old_val & ~m) | (di & m);
`ifdef PCIECFG_TARGET_RW1C_EN
        if (addr == 10'(PCIECFG_STATUS_DW))
            wr_val[31:16] = old_val[31:16] & ~(di[31:16] & m[31:16]);
`endif
    end

    // Status events are merged after the write so a same-cycle set always wins.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) regs_d[a] = regs_q[a];
        if (wr_en && in_range) regs_d[idx] = wr_val;
        regs_d[PCIECFG_STATUS_DW][31:16] = regs_d[PCIECFG_STATUS_DW][31:16] | status_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) regs_q[a] <= PCIECFG_INIT[a];
        end else begin
            for (int a = 0; a < DEPTH; a++) regs_q[a] <= regs_d[a];
        end
    end

endmodule

// File: rtl/pciecfg_target.sv
// cfg_mgmt responder: accepts one dword request, pulses done ACK_LATENCY
// cycles later, then spends one RECOVER cycle ignoring enables.
module pciecfg_target
    import pciecfg_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int ACK_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  cfg_mgmt_dwaddr,
    input  logic        cfg_mgmt_rd_en,
    input  logic        cfg_mgmt_wr_en,
    input  logic [3:0]  cfg_mgmt_byte_en,
    input  logic [31:0] cfg_mgmt_di,
    output logic [31:0] cfg_mgmt_do,
    output logic        cfg_mgmt_rd_wr_done,
    input  logic [15:0] status_set,
    output logic [15:0] cfg_command
);
    localparam int CW = $clog2(ACK_LATENCY + 1);

    pciecfg_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [9:0]     addr_q, addr_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    di_q, di_d;
    logic           wr_q, wr_d;
    logic           done_q, done_d;
    logic [31:0]    do_q, do_d;
    logic [15:0]    cmd_q, cmd_d;

    logic           use_in;
    logic [9:0]     c_addr;
    logic [3:0]     c_be;
    logic [31:0]    c_di;
    logic           c_wr;
    logic [31:0]    rd_data;
    logic [15:0]    command;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        di_d    = di_q;
        wr_d    = wr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_mgmt_rd_en || cfg_mgmt_wr_en) begin
                    addr_d  = cfg_mgmt_dwaddr;
                    be_d    = cfg_mgmt_byte_en;
                    di_d    = cfg_mgmt_di;
                    wr_d    = cfg_mgmt_wr_en;
                    cnt_d   = CW'(ACK_LATENCY - 1);
                    state_d = ST_BUSY;
                    if (ACK_LATENCY == 1) done_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) done_d = 1'b1;
                end
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // done is registered, so the commit happens on the edge that raises it;
    // with ACK_LATENCY==1 that edge is the accept edge and uses live inputs.
    assign use_in = (state_q == ST_IDLE);
    assign c_addr = use_in ? cfg_mgmt_dwaddr  : addr_q;
    assign c_be   = use_in ? cfg_mgmt_byte_en : be_q;
    assign c_di   = use_in ? cfg_mgmt_di      : di_q;
    assign c_wr   = use_in ? cfg_mgmt_wr_en   : wr_q;

    assign do_d  = (done_d && !c_wr) ? rd_data : do_q;
    assign cmd_d = command;

    pciecfg_target_regs #(.DEPTH(DEPTH)) u_regs (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (done_d && c_wr),
        .addr       (c_addr),
        .byte_en    (c_be),
        .di         (c_di),
        .status_set (status_set),
        .rd_data    (rd_data),
        .command    (command)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            di_q    <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            do_q    <= '0;
            cmd_q   <= PCIECFG_INIT[PCIECFG_STATUS_DW][15:0];
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            di_q    <= di_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            do_q    <= do_d;
            cmd_q   <= cmd_d;
        end
    end

    assign cfg_mgmt_do         = do_q;
    assign cfg_mgmt_rd_wr_done = done_q;
    assign cfg_command         = cmd_q;

endmodule
